// File: rtl/regfile_loader.sv
// regfile_loader: holds the processor in reset, optionally zeroes r1..r31,
// streams (register, value) pairs into the regfile, then releases the
// processor and hands the regfile write port back to it.
module regfile_loader #(
  parameter int unsigned CLEAR_FIRST = 0,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        proc_we,
  input  logic [4:0]  proc_wr_reg,
  input  logic [31:0] proc_wr_data,
  output logic        proc_reset,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        busy,
  output logic        done,
  output logic [5:0]  load_count
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [REG_W-1:0] LAST_REG  = REG_W'(31);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(63);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t              state;
  logic [REG_W-1:0]    clear_idx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                ld_we;
  logic [REG_W-1:0]    ld_reg;
  logic [DATA_W-1:0]   ld_data;

  // Sequencer: clear sweep, pair acceptance, hold countdown and registered loader writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      clear_idx  <= '0;
      hold_cnt   <= '0;
      ld_we      <= 1'b0;
      ld_reg     <= '0;
      ld_data    <= '0;
      in_ready   <= 1'b0;
      proc_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            load_count <= '0;
            if (CLEAR_FIRST != 0) begin
              // First clear write (r1) lands at the edge after start.
              state     <= S_CLEAR;
              clear_idx <= REG_W'(1);
              ld_we     <= 1'b1;
              ld_reg    <= REG_W'(1);
              ld_data   <= '0;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          if (clear_idx == LAST_REG) begin
            state    <= S_LOAD;
            ld_we    <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            clear_idx <= clear_idx + REG_W'(1);
            ld_we     <= 1'b1;
            ld_reg    <= clear_idx + REG_W'(1);
            ld_data   <= '0;
          end
        end

        S_LOAD: begin
          ld_we <= 1'b0;
          if (in_valid && in_ready) begin
            // r0 pairs are consumed without touching the regfile or the count.
            if (in_reg != REG_W'(0)) begin
              ld_we   <= 1'b1;
              ld_reg  <= in_reg;
              ld_data <= in_data;
              if (load_count != CNT_MAX) begin
                load_count <= load_count + CNT_W'(1);
              end
            end
            if (in_last) begin
              state    <= S_HOLD;
              in_ready <= 1'b0;
              hold_cnt <= HOLD_W'(HOLD_CYCLES);
            end
          end
        end

        S_HOLD: begin
          ld_we <= 1'b0;
          if (hold_cnt == '0) begin
            state      <= S_RUN;
            proc_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        S_RUN: begin
          ld_we <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write port: processor drives it combinationally once running, loader registers otherwise
  assign ctrl_writeEnable = (state == S_RUN) ? proc_we      : ld_we;
  assign ctrl_writeReg    = (state == S_RUN) ? proc_wr_reg  : ld_reg;
  assign data_writeReg    = (state == S_RUN) ? proc_wr_data : ld_data;

endmodule
